// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between one output-port arbiter, its requesting input units
// and the downstream link. master = arbiter side, slave = requesters/downstream.
interface output_port_arbiter_if #(
  parameter int NUM_OF_PORTS = 5,
  parameter int PTR_W        = $clog2(NUM_OF_PORTS)
);
  logic [NUM_OF_PORTS-1:0] i_req;
  logic [NUM_OF_PORTS-1:0] i_tail;
  logic                    i_downstream_ack;
  logic [NUM_OF_PORTS-1:0] o_grant;
  logic [NUM_OF_PORTS-1:0] o_flit_ack;
  logic                    o_downstream_req;
  logic [PTR_W-1:0]        o_owner;
  logic                    o_busy;
  logic [15:0]             o_flit_cnt;
  logic                    o_timeout;

  modport master (
    input  i_req, i_tail, i_downstream_ack,
    output o_grant, o_flit_ack, o_downstream_req, o_owner, o_busy, o_flit_cnt, o_timeout
  );

  modport slave (
    output i_req, i_tail, i_downstream_ack,
    input  o_grant, o_flit_ack, o_downstream_req, o_owner, o_busy, o_flit_cnt, o_timeout
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin wormhole scheduler for one router output port.
// Optional ARB_WATCHDOG_EN: releases a stalled owner after TIMEOUT idle cycles.
//
// state  | meaning
// IDLE   | no owner; pick next requester round-robin from rr_ptr
// ACTIVE | locked to o_owner until its tail flit is accepted
module output_port_arbiter #(
  parameter int NUM_OF_PORTS = 5,
  parameter int PTR_W        = $clog2(NUM_OF_PORTS)
`ifdef ARB_WATCHDOG_EN
  , parameter int TIMEOUT    = 255
`endif
) (
  input logic                   clk,
  input logic                   reset_n,
  output_port_arbiter_if.master arb
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        owner_q;
  logic [PTR_W-1:0]        rr_ptr_q;
  logic [PTR_W-1:0]        next_ptr;
  logic [15:0]             flit_cnt_q;
  logic [PTR_W-1:0]        win_idx;
  logic                    win_found;
  logic                    active;
  logic                    req_own;
  logic                    tail_own;
  logic                    xfer;
  logic                    wd_fire;
  logic                    release_pkt;
  logic [NUM_OF_PORTS-1:0] grant_d;
  logic [NUM_OF_PORTS-1:0] flit_ack_d;
  logic                    dreq_d;
  logic                    busy_d;

  assign active      = (state_q == ACTIVE);
  assign req_own     = arb.i_req[owner_q];
  assign tail_own    = arb.i_tail[owner_q];
  assign xfer        = active && req_own && arb.i_downstream_ack;
  assign release_pkt = active && ((xfer && tail_own) || wd_fire);
  assign next_ptr    = (owner_q == PTR_W'(NUM_OF_PORTS-1)) ? '0 : owner_q + PTR_W'(1);

  // First requester at or above rr_ptr, wrapping past the top port.
  always_comb begin
    int               cand_sum;
    logic [PTR_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = 0;
    cand      = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      cand_sum = int'(rr_ptr_q) + i;
      if (cand_sum >= NUM_OF_PORTS) cand_sum = cand_sum - NUM_OF_PORTS;
      cand = PTR_W'(cand_sum);
      if (!win_found && arb.i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] idle_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            idle_cnt_q <= '0;
    else if (!active || xfer) idle_cnt_q <= '0;
    else                     idle_cnt_q <= idle_cnt_q + WD_W'(1);
  end

  // Fires in the TIMEOUT-th consecutive ACTIVE cycle without a transfer.
  assign wd_fire = active && !xfer && (idle_cnt_q == WD_W'(TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = ACTIVE;
      ACTIVE:  if (release_pkt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = '0;
    flit_ack_d = '0;
    dreq_d     = 1'b0;
    busy_d     = 1'b0;
    if (active) begin
      grant_d[owner_q] = 1'b1;
      busy_d           = 1'b1;
      dreq_d           = req_own;
      if (xfer) flit_ack_d[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      flit_cnt_q <= '0;
    end else begin
      if (!active && win_found) owner_q <= win_idx;
      if (release_pkt)          rr_ptr_q <= next_ptr;
      if (xfer && (flit_cnt_q != 16'hFFFF)) flit_cnt_q <= flit_cnt_q + 16'd1;
    end
  end

  assign arb.o_grant          = grant_d;
  assign arb.o_flit_ack       = flit_ack_d;
  assign arb.o_downstream_req = dreq_d;
  assign arb.o_owner          = owner_q;
  assign arb.o_busy           = busy_d;
  assign arb.o_flit_cnt       = flit_cnt_q;
  assign arb.o_timeout        = wd_fire;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: expected flit acks are queued by the
// stimulus and popped by an independent monitor whenever the DUT acks a flit.
module tb_output_port_arbiter;

  localparam int N = 5;

  typedef struct {
    logic [N-1:0] ack;
    int           cnt;
  } exp_t;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;
  int   exp_cnt;
  exp_t exp_q[$];

  output_port_arbiter_if #(.NUM_OF_PORTS(N)) bus ();

`ifdef ARB_WATCHDOG_EN
  output_port_arbiter #(.NUM_OF_PORTS(N), .TIMEOUT(10)) dut (
    .clk(clk), .reset_n(reset_n), .arb(bus)
  );
`else
  output_port_arbiter #(.NUM_OF_PORTS(N)) dut (
    .clk(clk), .reset_n(reset_n), .arb(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive inputs just after the edge, queue an expected ack if the
  // cycle should carry a transfer, then stop mid-cycle for sampling.
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] tail,
                      input logic ack, input int xfer_port);
    @(posedge clk);
    #1;
    bus.i_req            = req;
    bus.i_tail           = tail;
    bus.i_downstream_ack = ack;
    if (xfer_port >= 0) begin
      exp_q.push_back('{ack: N'(1) << xfer_port, cnt: exp_cnt});
      exp_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n              = 1'b0;
    bus.i_req            = '0;
    bus.i_tail           = '0;
    bus.i_downstream_ack = 1'b0;
    exp_cnt              = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.o_flit_ack != '0) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_ack: got %b expected none at %0t", bus.o_flit_ack, $time);
        end else begin
          e = exp_q.pop_front();
          check("flit_ack", 32'(bus.o_flit_ack), 32'(e.ack));
          check("flit_cnt_before_xfer", 32'(bus.o_flit_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin : stim
    int hit;
    pass_cnt  = 0;
    total_cnt = 0;
    exp_cnt   = 0;
    reset_n              = 1'b0;
    bus.i_req            = '0;
    bus.i_tail           = '0;
    bus.i_downstream_ack = 1'b0;
    @(negedge clk);
    check("rst_grant", 32'(bus.o_grant), 0);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_owner", 32'(bus.o_owner), 0);
    check("rst_cnt", 32'(bus.o_flit_cnt), 0);
    check("rst_dreq", 32'(bus.o_downstream_req), 0);
    check("rst_timeout", 32'(bus.o_timeout), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single-flit packet on port 2, then rr_ptr=3 favours port 4 over port 0.
    step(5'b00100, 5'b00100, 1'b1, -1);
    check("t1_idle_grant", 32'(bus.o_grant), 0);
    step(5'b00100, 5'b00100, 1'b1, 2);
    check("t1_grant", 32'(bus.o_grant), 32'(5'b00100));
    check("t1_owner", 32'(bus.o_owner), 2);
    check("t1_busy", 32'(bus.o_busy), 1);
    step(5'b10001, 5'b10001, 1'b1, -1);
    check("t1_bubble", 32'(bus.o_grant), 0);
    check("t1_cnt", 32'(bus.o_flit_cnt), 1);
    step(5'b10001, 5'b10001, 1'b1, 4);
    check("t1_rr_grant", 32'(bus.o_grant), 32'(5'b10000));
    step(5'b00000, 5'b00000, 1'b0, -1);
    check("t1_cnt2", 32'(bus.o_flit_cnt), 2);

    // Two constant requesters, 3-flit packets: 0, 4, 0 with bubbles.
    do_reset();
    step(5'b10001, 5'b00000, 1'b1, -1);
    step(5'b10001, 5'b00000, 1'b1, 0);
    check("t2_grant_a", 32'(bus.o_grant), 32'(5'b00001));
    step(5'b10001, 5'b00000, 1'b1, 0);
    step(5'b10001, 5'b00001, 1'b1, 0);
    step(5'b10001, 5'b00000, 1'b1, -1);
    check("t2_bubble_a", 32'(bus.o_grant), 0);
    step(5'b10001, 5'b00000, 1'b1, 4);
    check("t2_grant_b", 32'(bus.o_grant), 32'(5'b10000));
    step(5'b10001, 5'b00000, 1'b1, 4);
    step(5'b10001, 5'b10000, 1'b1, 4);
    step(5'b10001, 5'b00000, 1'b1, -1);
    check("t2_bubble_b", 32'(bus.o_grant), 0);
    step(5'b10001, 5'b00000, 1'b1, 0);
    check("t2_grant_c", 32'(bus.o_grant), 32'(5'b00001));
    step(5'b10001, 5'b00000, 1'b1, 0);
    step(5'b10001, 5'b00001, 1'b1, 0);
    step(5'b00000, 5'b00000, 1'b0, -1);
    check("t2_cnt", 32'(bus.o_flit_cnt), 9);

    // Owner port 1 stalls mid-packet while port 3 waits: lock must hold.
    step(5'b01010, 5'b00000, 1'b1, -1);
    step(5'b01010, 5'b00000, 1'b1, 1);
    check("t3_owner", 32'(bus.o_owner), 1);
    for (int k = 0; k < 4; k++) begin
      step(5'b01000, 5'b01000, 1'b1, -1);
      check("t3_hold_grant", 32'(bus.o_grant), 32'(5'b00010));
      check("t3_hold_dreq", 32'(bus.o_downstream_req), 0);
    end
    step(5'b01010, 5'b00000, 1'b1, 1);
    step(5'b01010, 5'b00010, 1'b1, 1);
    step(5'b01000, 5'b01000, 1'b1, -1);
    check("t3_bubble", 32'(bus.o_grant), 0);
    step(5'b01000, 5'b01000, 1'b1, 3);
    check("t3_next_owner", 32'(bus.o_grant), 32'(5'b01000));
    step(5'b00000, 5'b00000, 1'b0, -1);

    // Downstream back-pressure on a head flit; stray ack with no request.
    step(5'b00001, 5'b00000, 1'b0, -1);
    for (int k = 0; k < 3; k++) begin
      step(5'b00001, 5'b00000, 1'b0, -1);
      check("t4_wait_dreq", 32'(bus.o_downstream_req), 1);
      check("t4_wait_noack", 32'(bus.o_flit_ack), 0);
    end
    step(5'b00001, 5'b00000, 1'b1, 0);
    step(5'b00000, 5'b00000, 1'b1, -1);
    check("t4_stray_dreq", 32'(bus.o_downstream_req), 0);
    check("t4_stray_noack", 32'(bus.o_flit_ack), 0);
    step(5'b00001, 5'b00001, 1'b1, 0);
    check("t4_stray_cnt", 32'(bus.o_flit_cnt), 32'(exp_cnt - 1));
    step(5'b00000, 5'b00000, 1'b0, -1);
    check("t4_cnt", 32'(bus.o_flit_cnt), 32'(exp_cnt));

    // Asynchronous reset during flit 2 of a 4-flit packet.
    step(5'b00100, 5'b00000, 1'b1, -1);
    step(5'b00100, 5'b00000, 1'b1, 2);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    check("t5_rst_grant", 32'(bus.o_grant), 0);
    check("t5_rst_busy", 32'(bus.o_busy), 0);
    check("t5_rst_dreq", 32'(bus.o_downstream_req), 0);
    check("t5_rst_cnt", 32'(bus.o_flit_cnt), 0);
    @(posedge clk);
    #1;
    reset_n              = 1'b1;
    bus.i_req            = '0;
    bus.i_downstream_ack = 1'b0;
    step(5'b01001, 5'b01001, 1'b1, -1);
    check("t5_idle_grant", 32'(bus.o_grant), 0);
    step(5'b01001, 5'b01001, 1'b1, 0);
    check("t5_rr_reset_grant", 32'(bus.o_grant), 32'(5'b00001));
    step(5'b00000, 5'b00000, 1'b0, -1);

    // Owner stalls with its request dropped while port 4 waits.
    step(5'b00100, 5'b00000, 1'b1, -1);
`ifdef ARB_WATCHDOG_EN
    hit = -1;
    for (int k = 1; k <= 20 && hit < 0; k++) begin
      step(5'b10000, 5'b10000, 1'b1, -1);
      if (bus.o_timeout) hit = k;
    end
    check("t6_wd_cycle", 32'(hit), 10);
    step(5'b10000, 5'b10000, 1'b1, -1);
    check("t6_wd_idle", 32'(bus.o_grant), 0);
    check("t6_wd_pulse_end", 32'(bus.o_timeout), 0);
    step(5'b10000, 5'b10000, 1'b1, 4);
    check("t6_wd_next", 32'(bus.o_grant), 32'(5'b10000));
`else
    hit = 0;
    for (int k = 0; k < 100; k++) begin
      step(5'b10000, 5'b10000, 1'b1, -1);
      if (bus.o_grant == 5'b00100 && !bus.o_timeout) hit++;
    end
    check("t6_lock_cycles", 32'(hit), 100);
    step(5'b00100, 5'b00100, 1'b1, 2);
    check("t6_resume_grant", 32'(bus.o_grant), 32'(5'b00100));
`endif
    step(5'b00000, 5'b00000, 1'b0, -1);
    check("end_cnt", 32'(bus.o_flit_cnt), 32'(exp_cnt));
    step(5'b00000, 5'b00000, 1'b0, -1);
    check("sb_drain", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
